// File: rtl/riscv_gnt_stall_pkg.sv
// Shared perturbation-model definitions: stall mode encodings used by both the
// request-side grant stall and the response-side rvalid stall.
package perturbation_pkg;

  typedef enum logic [31:0] {
    NO_STALL = 32'd0,
    STANDARD = 32'd1,
    RANDOM   = 32'd2
  } stall_mode_e;

  localparam int unsigned MAX_STALL_CYCLES = 15;

  typedef enum logic {
    IDLE,
    STALL
  } gnt_state_e;

endpackage

// File: rtl/riscv_gnt_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running after reset.
// Optional LFSR-lockup check under RISCV_GNT_STALL_ASSERT_EN.
module riscv_stall_lfsr #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [OUT_W-1:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q[OUT_W-1:0];

`ifdef RISCV_GNT_STALL_ASSERT_EN
  a_lfsr_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni) lfsr_q != '0)
    else $error("lfsr reached zero");
`endif

endmodule

// File: rtl/riscv_gnt_stall.sv
// OBI request-side perturbation: delays gnt_o and caps outstanding transactions.
// Protocol assertions available with RISCV_GNT_STALL_ASSERT_EN.
module riscv_gnt_stall
  import perturbation_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DELAY_WL        = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               req_i,
  input  logic [31:0]                        addr_i,
  input  logic                               we_i,
  input  logic [3:0]                         be_i,
  input  logic [31:0]                        wdata_i,
  output logic                               gnt_o,
  input  logic                               rvalid_i,
  output logic                               mem_req_o,
  output logic [31:0]                        mem_addr_o,
  output logic                               mem_we_o,
  output logic [3:0]                         mem_be_o,
  output logic [31:0]                        mem_wdata_o,
  input  logic                               en_stall_i,
  input  logic [31:0]                        stall_mode_i,
  input  logic [31:0]                        max_stall_i,
  input  logic [31:0]                        gnt_stall_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

  localparam int unsigned OW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [31:0] DMAX = 32'((1 << DELAY_WL) - 1);

  gnt_state_e          state_q, state_d;
  logic [DELAY_WL-1:0] cnt_q, cnt_d;
  logic [OW-1:0]       out_q, out_d;
  logic [DELAY_WL-1:0] lfsr;
  logic [DELAY_WL-1:0] delay, rnd_lim;
  logic [DELAY_WL:0]   rnd_mod;
  logic                room, gnt, inc, dec;

  riscv_stall_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (DELAY_WL)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lfsr_o (lfsr)
  );

  // Knobs are saturated to the counter range before use; modulo keeps RANDOM in 0..m.
  always_comb begin
    delay   = '0;
    rnd_lim = (max_stall_i > DMAX) ? DMAX[DELAY_WL-1:0] : max_stall_i[DELAY_WL-1:0];
    rnd_mod = {1'b0, rnd_lim} + (DELAY_WL+1)'(1);
    if (en_stall_i) begin
      if (stall_mode_i == STANDARD) begin
        delay = (gnt_stall_i > DMAX) ? DMAX[DELAY_WL-1:0] : gnt_stall_i[DELAY_WL-1:0];
      end else if (stall_mode_i == RANDOM) begin
        delay = DELAY_WL'({1'b0, lfsr} % rnd_mod);
      end
    end
  end

  assign room = (out_q < OW'(MAX_OUTSTANDING));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (delay == '0) begin
            gnt = room;
          end else begin
            cnt_d   = delay - DELAY_WL'(1);
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!req_i) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_WL'(1);
        end else begin
          gnt = room;
          if (room) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o     = gnt & rst_ni;
  assign mem_req_o = req_i & gnt_o;

  assign inc = req_i & gnt_o;
  assign dec = rvalid_i & (out_q != '0);

  always_comb begin
    out_d = out_q;
    if (inc && !dec)      out_d = out_q + OW'(1);
    else if (dec && !inc) out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign outstanding_o = out_q;
  assign mem_addr_o    = addr_i;
  assign mem_we_o      = we_i;
  assign mem_be_o      = be_i;
  assign mem_wdata_o   = wdata_i;

`ifdef RISCV_GNT_STALL_ASSERT_EN
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == STALL) |-> req_i)
    else $error("req_i dropped while stalled");
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> ($stable(addr_i) && $stable(we_i) && $stable(be_i) && $stable(wdata_i)))
    else $error("request payload changed before grant");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_q <= OW'(MAX_OUTSTANDING))
    else $error("outstanding overflow");
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> (out_q != '0))
    else $error("rvalid_i with no outstanding transaction");
`endif

endmodule
